timer_ctrl: RTL
===============

# timer_ctrl

Sequencer for the team's 5-bit up-counter/buzzer datapath. It accepts start, pause and stop commands, counts qualified `tick` pulses up to a latched target, and raises the buzzer for a fixed number of ticks. It then returns to idle, or restarts when auto-reload is compiled in. The block sits between the push-button or debounce logic and the buzzer driver, and replaces free-running counter-plus-reset gating with an explicit state machine.

## Interface
Parameters:
- `WIDTH`, 5: count and target width.
- `BUZZ_TICKS`, 4: ticks the buzzer stays on in ALARM; legal range 1..255.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high. It clears every register on the next edge.
- `tick`, in, 1: count-enable pulse, one cycle wide.
- `start`, in, 1: start/resume command, one-cycle pulse.
- `pause`, in, 1: pause command, one-cycle pulse.
- `stop`, in, 1: abort command, one-cycle pulse.
- `target`, in, WIDTH: terminal count. It is sampled only when a start is accepted in IDLE.
- `count`, out, WIDTH: current count, registered.
- `state`, out, 2: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- `busy`, out, 1: high in RUN, PAUSE or ALARM.
- `buzzer`, out, 1: high exactly while in ALARM.
- `done`, out, 1: one-cycle pulse on the cycle ALARM is entered.

## Operation
- Reset values: state IDLE, `count` 0, `target_q` 0, buzz counter 0, `buzzer` 0, `done` 0, `busy` 0.
- Command priority, every state: `stop` > `pause` > `start` > `tick`.
- IDLE:
  - `start` with `stop` low: latch `target` into `target_q` and clear `count`.
  - If `target` = 0, go to ALARM directly and pulse `done`. Otherwise go to RUN.
  - `tick` and `pause` are ignored.
- RUN:
  - `stop` goes to IDLE with `count` cleared.
  - `pause` goes to PAUSE with `count` held.
  - `tick` increments `count`. If the incremented value equals `target_q`, go to ALARM, pulse `done`, and load the buzz counter with `BUZZ_TICKS`.
  - `start` is ignored.
- PAUSE:
  - `stop` goes to IDLE with `count` cleared.
  - `start` goes to RUN; `target` is not re-sampled.
  - `tick` is ignored and `count` is held.
- ALARM:
  - `count` holds `target_q`.
  - Each `tick` decrements the buzz counter. A `tick` while it equals 1 ends the alarm.
  - `stop` goes to IDLE immediately with `count` cleared.
  - `pause` and `start` are ignored.
- Alarm end: go to IDLE with `count` 0, or follow the auto-reload rule (see Configuration).
- Arithmetic: `count` is unsigned WIDTH-bit and never exceeds `target_q`, so no wrap occurs. `target` = 2^WIDTH−1 (31 at default) is legal.
- `reset` asserted mid-operation, in any state, wins over all commands on that edge.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- A command sampled at edge N takes effect on outputs after edge N. Latency is 1 cycle.
- `done` and `buzzer` rise after the same edge as the terminal tick. `done` falls one edge later.
- With `target` = T ≥ 1 and a tick every cycle, ALARM is entered T edges after RUN is entered.
- `buzzer` stays high for exactly `BUZZ_TICKS` ticks. With back-to-back ticks that is `BUZZ_TICKS` cycles.
- Multi-cycle command pulses are not edge-detected; each high cycle is a new command.

## Configuration
- Macro: `TIMER_CTRL_AUTORELOAD_EN`.
- Defined: alarm end goes to RUN with `count` 0 and `target_q` retained, and counting resumes on the next tick. If `target_q` = 0, alarm end goes to IDLE instead, to avoid a permanent alarm loop.
- Undefined: alarm end always goes to IDLE with `count` 0.
- `stop` behaviour is identical either way.

## Structure
- Package `timer_ctrl_pkg` holds:
  - the state encoding constants IDLE/RUN/PAUSE/ALARM;
  - the 2-bit state type;
  - the default `BUZZ_TICKS` value.
- One sub-module, `buzz_timer`: a loadable down-counter with inputs `load`, `dec` and `load_val`, and output `expire`. It is a pulse when decremented at 1.
- `timer_ctrl` instantiates `buzz_timer` and owns the state register, `count` and `target_q`.

## Test plan
- Basic run:
  - Stimulus: reset, then `target`=5, `start`, then continuous `tick`.
  - Required: `count` steps 1..5; `done` pulses once when `count`=5; `buzzer` high 4 cycles; then IDLE with `count`=0.
- Pause/resume:
  - Stimulus: `target`=10, pause at `count`=3, 6 ticks while paused, then `start`.
  - Required: `count` stays 3 while paused, resumes at 4, and reaches ALARM on the 7th tick after resume.
- Priority and zero target:
  - Stimulus: `start`+`stop` together in IDLE.
  - Required: stays IDLE.
  - Stimulus: `start` with `target`=0.
  - Required: ALARM and `done` after one edge.
- Max target:
  - Stimulus: `target`=31 with continuous ticks.
  - Required: reaches 31 with no wrap; ALARM entered; `count` held at 31 during the buzzer.
- Abort and reset:
  - Stimulus: `stop` in the 2nd ALARM cycle.
  - Required: `buzzer` low and IDLE next cycle.
  - Stimulus: `reset` in RUN at `count`=7.
  - Required: all outputs at reset values after one edge.
- Auto-reload (`TIMER_CTRL_AUTORELOAD_EN` defined):
  - Stimulus: `target`=3 with continuous ticks.
  - Required: alarm end goes to RUN with `count`=0; a second `done` follows 3 ticks later.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer_ctrl sequencer and its buzz timer.
package timer_ctrl_pkg;

   // Encoding is visible on the state output: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StAlarm = 2'd3
   } state_e;

   localparam int unsigned BuzzTicksDefault = 4;
   localparam int unsigned BuzzWidth        = 8;

endpackage

// File: rtl/buzz_timer.sv
// Loadable down-counter timing the alarm phase; expire pulses when decremented at 1.
module buzz_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   assign expire = dec && !load && (cnt_q == W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Start/pause/stop sequencer for the up-counter/buzzer datapath.
// Optional feature: define TIMER_CTRL_AUTORELOAD_EN to restart counting after each alarm.
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = 5,
   parameter int unsigned BUZZ_TICKS = BuzzTicksDefault
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             busy,
   output logic             buzzer,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] count_inc;
   logic             buzz_load;
   logic             buzz_dec;
   logic             buzz_expire;

   buzz_timer #(
      .W (BuzzWidth)
   ) u_buzz_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (buzz_load),
      .dec      (buzz_dec),
      .load_val (BuzzWidth'(BUZZ_TICKS)),
      .expire   (buzz_expire)
   );

   assign count_inc = count_q + WIDTH'(1);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      target_d  = target_q;
      done_d    = 1'b0;
      buzz_load = 1'b0;
      buzz_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               target_d = target;
               count_d  = '0;
               if (target == '0) begin
                  state_d   = StAlarm;
                  done_d    = 1'b1;
                  buzz_load = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
               count_d = '0;
            end else if (pause) begin
               state_d = StPause;
            end else if (tick) begin
               count_d = count_inc;
               if (count_inc == target_q) begin
                  state_d   = StAlarm;
                  done_d    = 1'b1;
                  buzz_load = 1'b1;
               end
            end
         end
         StPause: begin
            if (stop) begin
               state_d = StIdle;
               count_d = '0;
            end else if (start) begin
               state_d = StRun;
            end
         end
         StAlarm: begin
            count_d = target_q;
            if (stop) begin
               state_d = StIdle;
               count_d = '0;
            end else if (tick) begin
               buzz_dec = 1'b1;
               if (buzz_expire) begin
                  count_d = '0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                  // A zero target would re-enter ALARM forever, so it falls back to idle.
                  state_d = (target_q != '0) ? StRun : StIdle;
`else
                  state_d = StIdle;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         target_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         done_q   <= done_d;
      end
   end

   assign count  = count_q;
   assign state  = state_q;
   assign busy   = (state_q != StIdle);
   assign buzzer = (state_q == StAlarm);
   assign done   = done_q;

endmodule
